vga_rx_monitor: RTL and testbench

// Receive end of the VGA output interface: samples VGA_R/G/B, VGA_HS, VGA_VS, VGA_BLANK_N from the VGA

---
 rtl/vga_rx_monitor_pkg.sv | 21 ++
 rtl/vga_rx_monitor_if.sv | 12 +
 rtl/vga_rx_monitor_edge_det.sv | 36 +++
 rtl/vga_rx_monitor.sv | 191 +++++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/vga_rx_monitor_pkg.sv
// Shared timing constants, FSM state type and counter helper for the VGA receive monitor.
package vga_rx_monitor_pkg;

   // 640x480@60 nominal timing
   localparam int unsigned NomHTotal  = 800;
   localparam int unsigned NomVTotal  = 525;
   localparam int unsigned NomHActive = 640;
   localparam int unsigned NomVActive = 480;

   localparam int unsigned CntW = 11;

   typedef logic [CntW-1:0] cnt_t;
   typedef logic [CntW:0]   len_t;

   typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

   function automatic cnt_t sat_inc(cnt_t v, logic en);
      return (en && (v != '1)) ? v + cnt_t'(1) : v;
   endfunction

endpackage

// File: rtl/vga_rx_monitor_if.sv
// VGA output bus as seen between the controller (master) and the monitor (slave).
interface vga_rx_monitor_if;
   logic [7:0] VGA_R;
   logic [7:0] VGA_G;
   logic [7:0] VGA_B;
   logic       VGA_HS;
   logic       VGA_VS;
   logic       VGA_BLANK_N;

   modport master (output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N);
   modport slave  (input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N);
endinterface

// File: rtl/vga_rx_monitor_edge_det.sv
// Two-stage input register with pulses on transitions to / away from the asserted level POL.
module vga_edge_det #(
   parameter bit POL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic lvl_o,
   output logic as_o,
   output logic ds_o
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;

   always_comb begin
      s1_d = d_i;
      s2_d = s1_q;
   end

   // Reset to the deasserted level so leaving reset never fakes an assert edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= ~POL;
         s2_q <= ~POL;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign lvl_o = s1_q;
   assign as_o  = (s1_q == POL) && (s2_q != POL);
   assign ds_o  = (s1_q != POL) && (s2_q == POL);

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA receive-side checker: recovers pixel coordinates, checks line/frame timing, checksums frames.
module vga_rx_monitor
   import vga_rx_monitor_pkg::*;
#(
   parameter int unsigned H_TOTAL  = NomHTotal,
   parameter int unsigned V_TOTAL  = NomVTotal,
   parameter int unsigned H_ACTIVE = NomHActive,
   parameter int unsigned V_ACTIVE = NomVActive,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   vga_rx_monitor_if.slave        vga,
   output logic                   pix_valid,
   output logic [10:0]            pix_x,
   output logic [10:0]            pix_y,
   output logic [7:0]             pix_r,
   output logic [7:0]             pix_g,
   output logic [7:0]             pix_b,
   output logic                   line_start,
   output logic                   frame_start,
   output logic                   locked,
   output logic                   err_hlen,
   output logic                   err_vlen,
   output logic [23:0]            frame_sum,
   output logic [15:0]            frame_cnt
);

   localparam len_t HTotal  = len_t'(H_TOTAL);
   localparam cnt_t HActive = cnt_t'(H_ACTIVE);
   localparam cnt_t VTotal  = cnt_t'(V_TOTAL);
   localparam cnt_t VActive = cnt_t'(V_ACTIVE);

   logic hs_lvl, hs_as, hs_ds;
   logic vs_lvl, vs_as, vs_ds;
   logic bl_lvl, bl_as, bl_fall;
   logic unused_edges;

   vga_edge_det #(.POL(SYNC_POL)) u_hs (
      .clk(clk), .rst(rst), .d_i(vga.VGA_HS), .lvl_o(hs_lvl), .as_o(hs_as), .ds_o(hs_ds));
   vga_edge_det #(.POL(SYNC_POL)) u_vs (
      .clk(clk), .rst(rst), .d_i(vga.VGA_VS), .lvl_o(vs_lvl), .as_o(vs_as), .ds_o(vs_ds));
   vga_edge_det #(.POL(1'b1)) u_bl (
      .clk(clk), .rst(rst), .d_i(vga.VGA_BLANK_N), .lvl_o(bl_lvl), .as_o(bl_as),
      .ds_o(bl_fall));

   assign unused_edges = ^{hs_lvl, vs_lvl, hs_ds, vs_ds, bl_as};

   logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
   cnt_t        h_cnt_q, h_cnt_d, act_cnt_q, act_cnt_d;
   cnt_t        v_cnt_q, v_cnt_d, y_cnt_q, y_cnt_d;
   logic        h_ref_q, h_ref_d, line_bad_q, line_bad_d;
   logic [23:0] acc_q, acc_d;
   state_e      state_q, state_d;

   logic        pix_valid_q, pix_valid_d, line_start_q, line_start_d;
   logic        frame_start_q, frame_start_d, locked_q, locked_d;
   logic        err_hlen_q, err_hlen_d, err_vlen_q, err_vlen_d;
   cnt_t        pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic [7:0]  pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;
   logic [23:0] frame_sum_q, frame_sum_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   logic [9:0]  rgb_sum;
   logic [23:0] acc_inc;
   cnt_t        y_inc;
   len_t        line_len;
   logic        line_bad, frame_bad, frame_end;

   always_comb begin
      r_d = vga.VGA_R;
      g_d = vga.VGA_G;
      b_d = vga.VGA_B;

      rgb_sum  = {2'b0, r_q} + {2'b0, g_q} + {2'b0, b_q};
      acc_inc  = acc_q + (bl_lvl ? {14'b0, rgb_sum} : 24'd0);
      y_inc    = sat_inc(y_cnt_q, bl_fall);
      line_len = {1'b0, h_cnt_q} + len_t'(1);
      // Lines with no active pixels (vertical blanking) are checked for length only
      line_bad  = hs_as && h_ref_q &&
                  ((line_len != HTotal) || ((act_cnt_q != '0) && (act_cnt_q != HActive)));
      frame_bad = (v_cnt_q != VTotal) || (y_inc != VActive);
      frame_end = vs_as && (state_q != StSearch);

      h_cnt_d    = hs_as ? '0 : sat_inc(h_cnt_q, 1'b1);
      act_cnt_d  = hs_as ? cnt_t'(bl_lvl) : sat_inc(act_cnt_q, bl_lvl);
      h_ref_d    = h_ref_q | hs_as;
      // A VS coinciding with HS opens the new frame with that line already counted
      v_cnt_d    = vs_as ? cnt_t'(hs_as) : sat_inc(v_cnt_q, hs_as);
      y_cnt_d    = vs_as ? '0 : y_inc;
      acc_d      = vs_as ? '0 : acc_inc;
      line_bad_d = vs_as ? 1'b0 : (line_bad_q | line_bad);

      state_d    = state_q;
      err_hlen_d = 1'b0;
      err_vlen_d = 1'b0;
      unique case (state_q)
         StSearch:  if (vs_as) state_d = StMeasure;
         StMeasure: if (vs_as && !line_bad_q && !line_bad && !frame_bad) state_d = StLocked;
         StLocked: begin
            err_hlen_d = line_bad;
            err_vlen_d = vs_as && frame_bad;
            if (err_hlen_d || err_vlen_d) state_d = StMeasure;
         end
         default:   state_d = StSearch;
      endcase

      // Holding on state_q too delays the drop by one cycle after an error pulse
      locked_d      = (state_d == StLocked) && (state_q != StSearch) ||
                      (state_q == StLocked);
      pix_valid_d   = bl_lvl && (state_q != StSearch);
      pix_x_d       = hs_as ? '0 : act_cnt_q;
      pix_y_d       = vs_as ? '0 : y_cnt_q;
      pix_r_d       = r_q;
      pix_g_d       = g_q;
      pix_b_d       = b_q;
      line_start_d  = hs_as;
      frame_start_d = vs_as;
      frame_sum_d   = frame_end ? acc_inc : frame_sum_q;
      frame_cnt_d   = frame_end ? frame_cnt_q + 16'd1 : frame_cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q           <= '0;
         g_q           <= '0;
         b_q           <= '0;
         h_cnt_q       <= '0;
         act_cnt_q     <= '0;
         v_cnt_q       <= '0;
         y_cnt_q       <= '0;
         h_ref_q       <= 1'b0;
         line_bad_q    <= 1'b0;
         acc_q         <= '0;
         state_q       <= StSearch;
         pix_valid_q   <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         pix_r_q       <= '0;
         pix_g_q       <= '0;
         pix_b_q       <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         locked_q      <= 1'b0;
         err_hlen_q    <= 1'b0;
         err_vlen_q    <= 1'b0;
         frame_sum_q   <= '0;
         frame_cnt_q   <= '0;
      end else begin
         r_q           <= r_d;
         g_q           <= g_d;
         b_q           <= b_d;
         h_cnt_q       <= h_cnt_d;
         act_cnt_q     <= act_cnt_d;
         v_cnt_q       <= v_cnt_d;
         y_cnt_q       <= y_cnt_d;
         h_ref_q       <= h_ref_d;
         line_bad_q    <= line_bad_d;
         acc_q         <= acc_d;
         state_q       <= state_d;
         pix_valid_q   <= pix_valid_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         pix_r_q       <= pix_r_d;
         pix_g_q       <= pix_g_d;
         pix_b_q       <= pix_b_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         locked_q      <= locked_d;
         err_hlen_q    <= err_hlen_d;
         err_vlen_q    <= err_vlen_d;
         frame_sum_q   <= frame_sum_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign pix_valid   = pix_valid_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign pix_r       = pix_r_q;
   assign pix_g       = pix_g_q;
   assign pix_b       = pix_b_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign locked      = locked_q;
   assign err_hlen    = err_hlen_q;
   assign err_vlen    = err_vlen_q;
   assign frame_sum   = frame_sum_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a scaled-down 20x12 raster (12x8 active), RGB = 1.
module tb_vga_rx_monitor;

   localparam int HT  = 20;
   localparam int HA  = 12;
   localparam int VT  = 12;
   localparam int VA  = 8;
   localparam int HS0 = 14;
   localparam int HS1 = 16;
   localparam int VSL = 9;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   vga_rx_monitor_if vif ();

   logic        pix_valid, line_start, frame_start, locked, err_hlen, err_vlen;
   logic [10:0] pix_x, pix_y;
   logic [7:0]  pix_r, pix_g, pix_b;
   logic [23:0] frame_sum;
   logic [15:0] frame_cnt;

   vga_rx_monitor #(
      .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .SYNC_POL(1'b0)
   ) dut (
      .clk(clk), .rst(rst), .vga(vif),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
      .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
      .line_start(line_start), .frame_start(frame_start), .locked(locked),
      .err_hlen(err_hlen), .err_vlen(err_vlen),
      .frame_sum(frame_sum), .frame_cnt(frame_cnt)
   );

   int total = 0;
   int bad   = 0;
   int ph = -1, pv = -1;
   int rst_h = -1, rst_v = -1;
   int n_errh, n_errv, n_fs;
   logic [23:0] last_sum;
   logic chk_pix = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One raster position; outputs seen afterwards belong to the previous position
   task automatic tick(input int h, input int v);
      logic act;
      act = (h < HA) && (v < VA);
      vif.VGA_BLANK_N = act;
      vif.VGA_HS = !((h >= HS0) && (h <= HS1));
      vif.VGA_VS = !(((v == VSL) && (h >= HS0)) || (v == VSL + 1) ||
                     ((v == VSL + 2) && (h < HS0)));
      vif.VGA_R = act ? 8'd1 : 8'd0;
      vif.VGA_G = act ? 8'd1 : 8'd0;
      vif.VGA_B = act ? 8'd1 : 8'd0;
      if (h == rst_h && v == rst_v) begin
         #2 rst = 1'b1;
         #1;
         check("rst_flags", {26'd0, pix_valid, line_start, frame_start, locked, err_hlen,
                             err_vlen}, 32'd0);
         check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
         check("rst_frame_sum", {8'd0, frame_sum}, 32'd0);
         rst_h = -1;
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      if (err_hlen) n_errh++;
      if (err_vlen) n_errv++;
      if (frame_start) begin
         n_fs++;
         last_sum = frame_sum;
      end
      if (chk_pix && ph == 0 && pv == 0) begin
         check("pix00_valid", {31'd0, pix_valid}, 32'd1);
         check("pix00_x", {21'd0, pix_x}, 32'd0);
         check("pix00_y", {21'd0, pix_y}, 32'd0);
         check("pix00_r", {24'd0, pix_r}, 32'd1);
      end
      if (chk_pix && ph == HA - 1 && pv == VA - 1) begin
         check("pixlast_valid", {31'd0, pix_valid}, 32'd1);
         check("pixlast_x", {21'd0, pix_x}, HA - 1);
         check("pixlast_y", {21'd0, pix_y}, VA - 1);
         check("pixlast_g", {24'd0, pix_g}, 32'd1);
      end
      if (chk_pix && ph == HA && pv == 0) check("blank_valid", {31'd0, pix_valid}, 32'd0);
      if (chk_pix && ph == HS0 && pv == 2) check("line_start", {31'd0, line_start}, 32'd1);
      ph = h;
      pv = v;
   endtask

   // nlines < VT drops line VSL-1; short_v loses one back-porch clock
   task automatic frame(input int nlines, input int short_v);
      n_errh = 0;
      n_errv = 0;
      n_fs   = 0;
      for (int v = 0; v < VT; v++) begin
         if (nlines < VT && v == VSL - 1) continue;
         for (int h = 0; h < HT; h++) begin
            if (v == short_v && h == HT - 2) continue;
            tick(h, v);
         end
      end
   endtask

   initial begin
      vif.VGA_HS = 1'b1;
      vif.VGA_VS = 1'b1;
      vif.VGA_BLANK_N = 1'b0;
      vif.VGA_R = 8'd0;
      vif.VGA_G = 8'd0;
      vif.VGA_B = 8'd0;
      last_sum = '0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_flags", {26'd0, pix_valid, line_start, frame_start, locked, err_hlen,
                            err_vlen}, 32'd0);
      check("reset_cnt", {16'd0, frame_cnt}, 32'd0);
      check("reset_sum", {8'd0, frame_sum}, 32'd0);
      rst = 1'b0;

      frame(VT, -1);
      check("f0_locked", {31'd0, locked}, 32'd0);
      check("f0_frame_cnt", {16'd0, frame_cnt}, 32'd0);
      check("f0_frame_starts", n_fs, 32'd1);

      chk_pix = 1'b1;
      frame(VT, -1);
      chk_pix = 1'b0;
      check("f1_locked", {31'd0, locked}, 32'd1);
      check("f1_frame_cnt", {16'd0, frame_cnt}, 32'd1);
      check("f1_sum", {8'd0, last_sum}, 3 * HA * VA);

      frame(VT, -1);
      check("f2_locked", {31'd0, locked}, 32'd1);
      check("f2_frame_cnt", {16'd0, frame_cnt}, 32'd2);
      check("f2_sum", {8'd0, last_sum}, 3 * HA * VA);
      check("f2_errh", n_errh, 32'd0);
      check("f2_errv", n_errv, 32'd0);

      frame(VT, 3);
      check("short_errh", n_errh, 32'd1);
      check("short_errv", n_errv, 32'd0);
      check("short_locked", {31'd0, locked}, 32'd0);
      check("short_frame_cnt", {16'd0, frame_cnt}, 32'd3);

      frame(VT, -1);
      check("relock_locked", {31'd0, locked}, 32'd1);
      check("relock_frame_cnt", {16'd0, frame_cnt}, 32'd4);

      frame(VT - 1, -1);
      check("vshort_errv", n_errv, 32'd1);
      check("vshort_errh", n_errh, 32'd0);
      check("vshort_locked", {31'd0, locked}, 32'd0);
      check("vshort_frame_cnt", {16'd0, frame_cnt}, 32'd5);

      frame(VT, -1);
      check("f6_locked", {31'd0, locked}, 32'd1);
      check("f6_frame_cnt", {16'd0, frame_cnt}, 32'd6);

      rst_h = 5;
      rst_v = 4;
      frame(VT, -1);
      check("postrst_locked", {31'd0, locked}, 32'd0);
      check("postrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
      check("postrst_errh", n_errh, 32'd0);
      check("postrst_errv", n_errv, 32'd0);

      frame(VT, -1);
      check("rst_relock", {31'd0, locked}, 32'd1);
      check("rst_relock_cnt", {16'd0, frame_cnt}, 32'd1);
      check("rst_relock_sum", {8'd0, last_sum}, 3 * HA * VA);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
